// File: rtl/mvm_sparse_encoder.sv
// Dense-to-sparse front end for the MVM accelerator: drops the zero elements of a
// row-major 4x4 frame and replays the rest as (row, column, value) triples.
module mvm_sparse_encoder #(
    parameter int FIFO_DEPTH = 16,
    parameter int EMIT_GAP   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       fetch_ready,
    output logic       sending_cpu,
    output logic [1:0] row_val,
    output logic [1:0] column_val,
    output logic [7:0] value,
    output logic       done_list,
    output logic [4:0] nnz_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = (EMIT_GAP > 1) ? $clog2(EMIT_GAP + 1) : 1;

    localparam logic [PW-1:0] LAST_SLOT  = PW'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LEVEL_ONE  = CW'(1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(EMIT_GAP);
    localparam logic [GW-1:0] GAP_ONE    = GW'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    logic [3:0]    pos;
    logic [4:0]    tally;
    logic [11:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] level;
    logic [GW-1:0] gap;
    logic [11:0]   head;
    logic          accept;
    logic          push;
    logic          pop;
    logic          emitting_state;

    // in_ready is held low while reset is asserted so the port reads 0 in reset.
    assign in_ready       = rst_n & ena & ((state == IDLE) || (state == LOAD));
    assign accept         = in_valid & in_ready;
    assign push           = accept & (in_data != 8'h00) & (level != FULL_LEVEL);
    assign emitting_state = (state == LOAD) || (state == DRAIN);
    // The gap counter is nonzero during the strobe cycle whenever EMIT_GAP > 0,
    // so it alone spaces strobes; EMIT_GAP = 0 lets a pop follow every cycle.
    assign pop            = ena & emitting_state & (level != '0) & fetch_ready & (gap == '0);
    assign head           = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pos, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sending_cpu <= 1'b0;
            row_val     <= 2'd0;
            column_val  <= 2'd0;
            value       <= 8'd0;
            gap         <= '0;
        end else begin
            sending_cpu <= pop;
            if (pop) begin
                row_val    <= head[11:10];
                column_val <= head[9:8];
                value      <= head[7:0];
                gap        <= GAP_LOAD;
            end else if (ena && (gap != '0)) begin
                gap <= gap - GAP_ONE;
            end
        end
    end

    // Frame sequencing; the non-zero tally restarts on the first accept of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pos       <= 4'd0;
            tally     <= 5'd0;
            done_list <= 1'b0;
            nnz_count <= 5'd0;
        end else begin
            done_list <= 1'b0;
            if (accept) begin
                pos   <= pos + 4'd1;
                tally <= ((state == IDLE) ? 5'd0 : tally) + {4'd0, push};
            end
            if (ena) begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (accept && (pos == 4'd15)) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if ((level == '0) && !sending_cpu) begin
                            state     <= DONE;
                            done_list <= 1'b1;
                            nnz_count <= tally;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mvm_sparse_encoder.sv
// Drives two encoders (EMIT_GAP 0 and 1) with one shared input stream and checks
// them against a frame-level model of expected triples and strobe timing.
module tb_mvm_sparse_encoder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic       fetch_ready;
    logic [7:0] in_data;

    logic       in_ready [2];
    logic       sending  [2];
    logic [1:0] row      [2];
    logic [1:0] col      [2];
    logic [7:0] value    [2];
    logic       done     [2];
    logic [4:0] nnz      [2];

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    logic fetch_prev = 1'b0;
    logic ena_prev   = 1'b0;
    bit   timing_on  = 1'b0;
    bit   rand_fetch = 1'b0;

    logic [11:0] exp_words  [$];
    int          exp_accept [$];
    int          frame_nnz;
    int          last_accept;
    logic [7:0]  frame_vals [16];

    int          strobe_cnt [2];
    int          done_cnt   [2];
    int          rd_idx     [2];
    int          last_t     [2];
    logic [11:0] last_word  [2];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_n     <= edge_n + 1;
        fetch_prev <= fetch_ready;
        ena_prev   <= ena;
    end

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        assert (got === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp_v);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        int model_t;

        mvm_sparse_encoder #(
            .FIFO_DEPTH(DEPTH),
            .EMIT_GAP  (g)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .ena        (ena),
            .in_valid   (in_valid),
            .in_data    (in_data),
            .in_ready   (in_ready[g]),
            .fetch_ready(fetch_ready),
            .sending_cpu(sending[g]),
            .row_val    (row[g]),
            .column_val (col[g]),
            .value      (value[g]),
            .done_list  (done[g]),
            .nnz_count  (nnz[g])
        );

        // Strobe and done monitor; the model time of strobe i is the later of
        // one cycle after its accept and EMIT_GAP+1 cycles after the previous one.
        initial forever begin
            @(negedge clk);
            if (sending[g]) begin
                strobe_cnt[g]++;
                check_output($sformatf("g%0d_pop_needs_fetch_and_ena", g),
                             32'({fetch_prev, ena_prev}), 32'd3);
                if (rd_idx[g] < exp_words.size()) begin
                    check_output($sformatf("g%0d_triple%0d", g, rd_idx[g]),
                                 32'({row[g], col[g], value[g]}), 32'(exp_words[rd_idx[g]]));
                    model_t = max2(exp_accept[rd_idx[g]] + 1, last_t[g] + g + 1);
                    if (timing_on) begin
                        check_output($sformatf("g%0d_strobe%0d_edge", g, rd_idx[g]), edge_n, model_t);
                    end
                    last_t[g]    = model_t;
                    last_word[g] = exp_words[rd_idx[g]];
                    rd_idx[g]++;
                end else begin
                    check_output($sformatf("g%0d_unexpected_strobe", g), 32'(sending[g]), 32'd0);
                end
            end
            if (done[g]) begin
                done_cnt[g]++;
                check_output($sformatf("g%0d_done_after_all_triples", g), rd_idx[g], exp_words.size());
                if (timing_on) begin
                    check_output($sformatf("g%0d_done_edge", g), edge_n,
                                 max2(last_accept + 1, last_t[g] + 2));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_fetch) begin
            fetch_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic begin_frame();
        exp_words.delete();
        exp_accept.delete();
        frame_nnz   = 0;
        last_accept = 0;
        for (int k = 0; k < 2; k++) begin
            strobe_cnt[k] = 0;
            done_cnt[k]   = 0;
            rd_idx[k]     = 0;
            last_t[k]     = -100;
        end
    endtask

    task automatic apply_stimulus(input int first, input int last, input int idle_max);
        int waited;
        int idle;
        for (int i = first; i <= last; i++) begin
            idle = int'($urandom_range(0, idle_max));
            repeat (idle) tick();
            waited = 0;
            while (!(in_ready[0] && in_ready[1]) && waited < 200) begin
                tick();
                waited++;
            end
            check_output($sformatf("in_ready_pos%0d", i), 32'(in_ready[0] & in_ready[1]), 32'd1);
            in_valid = 1'b1;
            in_data  = frame_vals[i];
            tick();
            if (frame_vals[i] != 8'h00) begin
                exp_words.push_back({i[3:0], frame_vals[i]});
                exp_accept.push_back(edge_n);
                frame_nnz++;
            end
            if (i == 15) begin
                last_accept = edge_n;
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((done_cnt[0] == 0 || done_cnt[1] == 0) && n < 400) begin
            tick();
            n++;
        end
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            check_output($sformatf("g%0d_done_pulses", k), done_cnt[k], 1);
            check_output($sformatf("g%0d_strobe_count", k), strobe_cnt[k], exp_words.size());
            check_output($sformatf("g%0d_nnz_count", k), 32'(nnz[k]), frame_nnz);
        end
    endtask

    task automatic run_frame(input int idle_max);
        begin_frame();
        apply_stimulus(0, 15, idle_max);
        wait_done();
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_output($sformatf("%s_g%0d_in_ready", tag, k), 32'(in_ready[k]), 32'd0);
            check_output($sformatf("%s_g%0d_sending", tag, k), 32'(sending[k]), 32'd0);
            check_output($sformatf("%s_g%0d_triple", tag, k), 32'({row[k], col[k], value[k]}), 32'd0);
            check_output($sformatf("%s_g%0d_done", tag, k), 32'(done[k]), 32'd0);
            check_output($sformatf("%s_g%0d_nnz", tag, k), 32'(nnz[k]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        ena         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        fetch_ready = 1'b1;
        last_word[0] = 12'd0;
        last_word[1] = 12'd0;
        begin_frame();
        #1;
        check_reset("reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        $display("[TB] identity frame");
        for (int i = 0; i < 16; i++) frame_vals[i] = (i / 4 == i % 4) ? 8'h01 : 8'h00;
        timing_on = 1'b1;
        run_frame(0);

        $display("[TB] all-0xFF frame");
        for (int i = 0; i < 16; i++) frame_vals[i] = 8'hFF;
        run_frame(0);
        check_output("g0_ff_strobes_vs_depth", strobe_cnt[0], DEPTH);

        $display("[TB] all-zero frame");
        for (int i = 0; i < 16; i++) frame_vals[i] = 8'h00;
        run_frame(0);

        $display("[TB] fetch stall frame");
        timing_on = 1'b0;
        for (int i = 0; i < 16; i++) frame_vals[i] = 8'h00;
        frame_vals[3]  = 8'd5;
        frame_vals[7]  = 8'd9;
        frame_vals[12] = 8'd200;
        fetch_ready = 1'b0;
        begin_frame();
        apply_stimulus(0, 15, 0);
        repeat (4) tick();
        check_output("g0_no_strobe_in_stall", strobe_cnt[0], 0);
        check_output("g1_no_strobe_in_stall", strobe_cnt[1], 0);
        fetch_ready = 1'b1;
        wait_done();

        $display("[TB] ena pause frame");
        for (int i = 0; i < 16; i++) frame_vals[i] = (i % 3 == 0) ? 8'h00 : 8'(8'h20 + i);
        begin_frame();
        apply_stimulus(0, 5, 0);
        ena      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                check_output($sformatf("pause%0d_g%0d_in_ready", c, k), 32'(in_ready[k]), 32'd0);
                check_output($sformatf("pause%0d_g%0d_sending", c, k), 32'(sending[k]), 32'd0);
                check_output($sformatf("pause%0d_g%0d_held_triple", c, k),
                             32'({row[k], col[k], value[k]}), 32'(last_word[k]));
            end
        end
        in_valid = 1'b0;
        ena      = 1'b1;
        apply_stimulus(6, 15, 0);
        wait_done();

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 16; i++) frame_vals[i] = 8'h00;
        frame_vals[1] = 8'h11;
        frame_vals[4] = 8'h44;
        frame_vals[6] = 8'h66;
        fetch_ready = 1'b0;
        begin_frame();
        apply_stimulus(0, 7, 0);
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        tick();
        tick();
        rst_n = 1'b1;
        fetch_ready = 1'b1;
        repeat (3) tick();
        check_output("g0_no_done_after_reset", done_cnt[0], 0);
        check_output("g1_no_done_after_reset", done_cnt[1], 0);
        check_output("g0_no_strobe_after_reset", strobe_cnt[0], 0);
        check_output("g1_no_strobe_after_reset", strobe_cnt[1], 0);

        $display("[TB] frame after reset");
        for (int i = 0; i < 16; i++) frame_vals[i] = (i % 2 == 0) ? 8'h00 : 8'(i * 17 + 3);
        timing_on = 1'b1;
        run_frame(0);

        $display("[TB] random frames");
        timing_on  = 1'b0;
        rand_fetch = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) begin
                frame_vals[i] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            run_frame(2);
        end
        rand_fetch  = 1'b0;
        fetch_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
